decoder: RTL and testbench

Latent-to-pixel decoder of the VAE datapath, directly downstream of the encoder. It consumes the two Q3.12 latent values `a1` and `a2` and evaluates nine neurons, one per pixel of the 3×3 image. Each neuron computes `y_i = sigmoid(W1[i]·a1 + W2[i]·a2 + B[i])` and thresholds the result to a 9-bit reconstructed image. The neurons are evaluated one after another on a single shared multiplier under a start/busy/done handshake, and each pixel probability is streamed out as it is produced.

---
 rtl/decoder.sv | 196 +++++++++++++++++++
 tb/tb_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// decoder: latent-to-pixel stage of the VAE datapath.
// Nine neurons y_i = sigmoid(W1[i]*a1 + W2[i]*a2 + B[i]) are evaluated one at a
// time on one shared multiplier. Each probability is streamed on p_valid/p_idx/p_out.
// Each result is also thresholded into a 9-bit image, which is presented on `out`
// at DONE.
// Optional feature macro: DECODER_SAT_EN. When it is defined, the pre-activation
// sum is clamped to the 16-bit signed range. When it is undefined, the sum wraps.
module decoder #(
  parameter int                         WIDTH  = 16,
  parameter int                         FRAC   = 12,
  parameter int                         N_OUT  = 9,
  parameter logic [WIDTH-1:0]           THRESH = 16'h0800,
  parameter logic [N_OUT*WIDTH-1:0]     W1_VEC = {16'h0A00, 16'hF400, 16'h1400, 16'h0600, 16'hEC00,
                                                  16'h1000, 16'hF800, 16'h0C00, 16'h1800},
  parameter logic [N_OUT*WIDTH-1:0]     W2_VEC = {16'hF000, 16'h0800, 16'h1200, 16'hE400, 16'h0400,
                                                  16'h1C00, 16'hFA00, 16'h0E00, 16'hF200},
  parameter logic [N_OUT*WIDTH-1:0]     B_VEC  = {16'h0100, 16'hFF00, 16'h0000, 16'h0200, 16'hFE00,
                                                  16'h0080, 16'h0000, 16'hFF80, 16'h0040}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] out,
  output logic             p_valid,
  output logic [3:0]       p_idx,
  output logic [WIDTH-1:0] p_out
);

  typedef enum logic [2:0] {S_IDLE, S_MUL1, S_MUL2, S_ACT, S_DONE} state_e;

  localparam int SW = 2 * WIDTH + 1;  // width of the product sum before scaling

  // Unpacked views of the trained weight/bias vectors, indexed by neuron.
  logic signed [WIDTH-1:0] w1_arr [N_OUT];
  logic signed [WIDTH-1:0] w2_arr [N_OUT];
  logic signed [WIDTH-1:0] b_arr  [N_OUT];

  for (genvar i = 0; i < N_OUT; i++) begin : g_unpack
    assign w1_arr[i] = W1_VEC[WIDTH*i +: WIDTH];
    assign w2_arr[i] = W2_VEC[WIDTH*i +: WIDTH];
    assign b_arr[i]  = B_VEC[WIDTH*i +: WIDTH];
  end

  state_e                    state_q, state_d;
  logic [3:0]                idx_q, idx_d;
  logic signed [WIDTH-1:0]   a1_q, a1_d, a2_q, a2_d;
  logic signed [2*WIDTH-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [N_OUT-1:0]          pix_q, pix_d, out_q, out_d;
  logic                      p_valid_q, p_valid_d;
  logic [3:0]                p_idx_q, p_idx_d;
  logic [WIDTH-1:0]          p_out_q, p_out_d;

  logic signed [WIDTH-1:0]   mul_a, mul_b;
  logic signed [2*WIDTH-1:0] mul_p;
  logic signed [SW-1:0]      sum_w, s_w;
  logic signed [WIDTH-1:0]   x_w;
  logic [WIDTH-1:0]          y_w;

  // Piecewise-linear (PLAN) sigmoid, evaluated on |x| and then mirrored for negative x.
  // The breakpoints assume a Q3.12 encoding.
  function automatic logic [WIDTH-1:0] sigmoid_plan(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] y;
    if (x == 16'sh8000)  m = 16'h7FFF;
    else if (x[WIDTH-1]) m = WIDTH'(-x);
    else                 m = x;
    if (m >= 16'h5000)      y = 16'h1000;
    else if (m >= 16'h2600) y = (m >> 5) + 16'h0D80;
    else if (m >= 16'h1000) y = (m >> 3) + 16'h0A00;
    else                    y = (m >> 2) + 16'h0800;
    if (x[WIDTH-1]) y = 16'h1000 - y;
    return y;
  endfunction

  // Shared multiplier: a1*W1[idx] in MUL1, a2*W2[idx] in MUL2.
  always_comb begin
    mul_a = a1_q;
    mul_b = w1_arr[idx_q];
    if (state_q == S_MUL2) begin
      mul_a = a2_q;
      mul_b = w2_arr[idx_q];
    end
    mul_p = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
  end

  // Pre-activation: floor-scale the product sum, add the bias, then reduce to 16 bits.
  always_comb begin
    sum_w = SW'(p1_q) + SW'(p2_q);
    s_w   = (sum_w >>> FRAC) + SW'(b_arr[idx_q]);
`ifdef DECODER_SAT_EN
    if (s_w > SW'(32767))       x_w = 16'sh7FFF;
    else if (s_w < -SW'(32768)) x_w = 16'sh8000;
    else                        x_w = s_w[WIDTH-1:0];
`else
    x_w = s_w[WIDTH-1:0];
`endif
    y_w = sigmoid_plan(x_w);
  end

`ifndef DECODER_SAT_EN
  // In wrap mode the bits above the result width are intentionally dropped.
  logic unused_s_hi;
  assign unused_s_hi = ^s_w[SW-1:WIDTH];
`endif

  // Next-state and datapath updates for the sequencing FSM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    pix_d     = pix_q;
    out_d     = out_q;
    p_valid_d = 1'b0;
    p_idx_d   = p_idx_q;
    p_out_d   = p_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a1_d    = a1;
          a2_d    = a2;
          idx_d   = '0;
          state_d = S_MUL1;
        end
      end
      S_MUL1: begin
        p1_d    = mul_p;
        state_d = S_MUL2;
      end
      S_MUL2: begin
        p2_d    = mul_p;
        state_d = S_ACT;
      end
      S_ACT: begin
        p_out_d      = y_w;
        p_idx_d      = idx_q;
        p_valid_d    = 1'b1;
        pix_d[idx_q] = (y_w >= THRESH);
        if (idx_q == 4'(N_OUT-1)) begin
          out_d   = pix_d;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_MUL1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      pix_q     <= '0;
      out_q     <= '0;
      p_valid_q <= 1'b0;
      p_idx_q   <= '0;
      p_out_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      pix_q     <= pix_d;
      out_q     <= out_d;
      p_valid_q <= p_valid_d;
      p_idx_q   <= p_idx_d;
      p_out_q   <= p_out_d;
    end
  end

  assign busy    = (state_q == S_MUL1) || (state_q == S_MUL2) || (state_q == S_ACT);
  assign done    = (state_q == S_DONE);
  assign out     = out_q;
  assign p_valid = p_valid_q;
  assign p_idx   = p_idx_q;
  assign p_out   = p_out_q;

endmodule

// File: tb/tb_decoder.sv
// Testbench for decoder. Four instances with different weight sets share the same
// stimulus. Every cycle of each decode is compared against expectations taken from
// a vector table and from an arithmetic reference model.
`timescale 1ns/1ps
module tb_decoder;

  localparam int NC = 4;
`ifdef DECODER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [143:0] TR_W1 = {16'hFC00, 16'h3000, 16'hC000, 16'h0000, 16'h2000,
                                    16'hE800, 16'h0400, 16'hF000, 16'h1800};
  localparam logic [143:0] TR_W2 = {16'h0100, 16'hD000, 16'h4000, 16'h0800, 16'hE000,
                                    16'h2400, 16'hF400, 16'h1000, 16'h0C00};
  localparam logic [143:0] TR_B  = {16'hFE00, 16'h0800, 16'h0000, 16'h0200, 16'hF000,
                                    16'h1000, 16'hFC00, 16'h0400, 16'h0000};

  // Config 0: all zero. 1: W1=1.0. 2: W1=W2=max. 3: mixed trained set.
  localparam logic [143:0] W1_T [NC] = '{{9{16'h0000}}, {9{16'h1000}}, {9{16'h7FFF}}, TR_W1};
  localparam logic [143:0] W2_T [NC] = '{{9{16'h0000}}, {9{16'h0000}}, {9{16'h7FFF}}, TR_W2};
  localparam logic [143:0] B_T  [NC] = '{{9{16'h0000}}, {9{16'h0000}}, {9{16'h0000}}, TR_B};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a1, a2;
  logic        busy_w [NC];
  logic        done_w [NC];
  logic        pv_w   [NC];
  logic [8:0]  out_w  [NC];
  logic [3:0]  pidx_w [NC];
  logic [15:0] pout_w [NC];

  for (genvar g = 0; g < NC; g++) begin : g_dut
    decoder #(
      .W1_VEC(W1_T[g]),
      .W2_VEC(W2_T[g]),
      .B_VEC (B_T[g])
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a1     (a1),
      .a2     (a2),
      .busy   (busy_w[g]),
      .done   (done_w[g]),
      .out    (out_w[g]),
      .p_valid(pv_w[g]),
      .p_idx  (pidx_w[g]),
      .p_out  (pout_w[g])
    );
  end

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_p    [NC][9];
  logic [8:0]  exp_o    [NC];
  logic [8:0]  out_prev [NC];

  typedef struct packed {
    logic [15:0]      a1;
    logic [15:0]      a2;
    logic [2:0][15:0] p;  // expected probability (same for every pixel) for configs 0..2
    logic [2:0][8:0]  o;  // expected image for configs 0..2
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkvec(input logic [15:0] va1, va2, p0, p1, p2,
                                 input logic [8:0] o0, o1, o2);
    vec_t v;
    v.a1 = va1;
    v.a2 = va2;
    v.p  = {p2, p1, p0};
    v.o  = {o2, o1, o0};
    return v;
  endfunction

  // Reference neuron: exact integer arithmetic following the datapath rules.
  function automatic logic [15:0] model_p(input int c, input int i,
                                          input logic [15:0] a1v, input logic [15:0] a2v);
    logic [143:0]       v1, v2, vb;
    logic signed [15:0] t;
    longint w1, w2, b, sa1, sa2, num, s, x, m, y;
    v1 = W1_T[c];
    v2 = W2_T[c];
    vb = B_T[c];
    t = v1[16*i +: 16]; w1 = t;
    t = v2[16*i +: 16]; w2 = t;
    t = vb[16*i +: 16]; b  = t;
    t = a1v; sa1 = t;
    t = a2v; sa2 = t;
    num = sa1 * w1 + sa2 * w2;
    s   = (num >>> 12) + b;
    if (SAT) begin
      x = (s > 32767) ? 64'sd32767 : ((s < -32768) ? -64'sd32768 : s);
    end else begin
      x = s & 64'hFFFF;
      if (x >= 32768) x = x - 65536;
    end
    m = (x < 0) ? -x : x;
    if (m > 32767) m = 32767;
    if (m >= 20480)     y = 4096;
    else if (m >= 9728) y = m / 32 + 3456;
    else if (m >= 4096) y = m / 8 + 2560;
    else                y = m / 4 + 2048;
    if (x < 0) y = 4096 - y;
    return 16'(y);
  endfunction

  task automatic fill_model(input int c, input logic [15:0] a1v, input logic [15:0] a2v);
    for (int i = 0; i < 9; i++) begin
      exp_p[c][i] = model_p(c, i, a1v, a2v);
      exp_o[c][i] = (exp_p[c][i] >= 16'h0800);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int g = 0; g < NC; g++) begin
      check($sformatf("%s busy c%0d", tag, g), 32'(busy_w[g]), 0);
      check($sformatf("%s done c%0d", tag, g), 32'(done_w[g]), 0);
      check($sformatf("%s p_valid c%0d", tag, g), 32'(pv_w[g]), 0);
      check($sformatf("%s out c%0d", tag, g), 32'(out_w[g]), 0);
      check($sformatf("%s p_idx c%0d", tag, g), 32'(pidx_w[g]), 0);
      check($sformatf("%s p_out c%0d", tag, g), 32'(pout_w[g]), 0);
    end
  endtask

  // One full decode, entered at a falling edge with the DUTs idle. Cycle n is the
  // interval after edge En (E0 = accepted start). With `pulses` set, start is also
  // raised so that it is sampled at E5 and E28, and both must be ignored.
  task automatic run_decode(input logic [15:0] a1v, input logic [15:0] a2v, input bit pulses);
    bit exp_pv;
    start = 1'b1;
    a1    = a1v;
    a2    = a2v;
    @(posedge clk);
    #1;
    start = 1'b0;
    a1    = 16'($urandom);
    a2    = 16'($urandom);
    for (int n = 0; n <= 28; n++) begin
      @(negedge clk);
      exp_pv = (n >= 3) && (n % 3 == 0);
      for (int g = 0; g < NC; g++) begin
        check($sformatf("busy c%0d n%0d", g, n), 32'(busy_w[g]), 32'(n <= 26));
        check($sformatf("done c%0d n%0d", g, n), 32'(done_w[g]), 32'(n == 27));
        check($sformatf("p_valid c%0d n%0d", g, n), 32'(pv_w[g]), 32'(exp_pv));
        if (exp_pv) begin
          check($sformatf("p_idx c%0d n%0d", g, n), 32'(pidx_w[g]), n / 3 - 1);
          check($sformatf("p_out c%0d px%0d", g, n / 3 - 1), 32'(pout_w[g]),
                32'(exp_p[g][n / 3 - 1]));
        end
        check($sformatf("out c%0d n%0d", g, n), 32'(out_w[g]),
              32'((n >= 27) ? exp_o[g] : out_prev[g]));
      end
      start = pulses && (n == 4 || n == 27);
      if (start) begin
        a1 = 16'($urandom);
        a2 = 16'($urandom);
      end
    end
    start = 1'b0;
    for (int g = 0; g < NC; g++) out_prev[g] = exp_o[g];
  endtask

  initial begin
    logic [15:0] edge_vals [4];
    logic [15:0] ra1, ra2;
    edge_vals[0] = 16'h8000;
    edge_vals[1] = 16'h7FFF;
    edge_vals[2] = 16'h0000;
    edge_vals[3] = 16'hFFFF;

    vecs[0] = mkvec(16'h1000, 16'h1000, 16'h0800, 16'h0C00, SAT ? 16'h1000 : 16'h0800,
                    9'h1FF, 9'h1FF, 9'h1FF);
    vecs[1] = mkvec(16'h2000, 16'h0000, 16'h0800, 16'h0E00, SAT ? 16'h1000 : 16'h0800,
                    9'h1FF, 9'h1FF, 9'h1FF);
    vecs[2] = mkvec(16'hE000, 16'h0000, 16'h0800, 16'h0200, SAT ? 16'h0000 : 16'h0800,
                    9'h1FF, 9'h000, SAT ? 9'h000 : 9'h1FF);
    vecs[3] = mkvec(16'h7FFF, 16'h7FFF, 16'h0800, 16'h1000, SAT ? 16'h1000 : 16'h07F8,
                    9'h1FF, 9'h1FF, SAT ? 9'h1FF : 9'h000);
    vecs[4] = mkvec(16'h0800, 16'hF000, 16'h0800, 16'h0A00, 16'h0080,
                    9'h1FF, 9'h1FF, 9'h000);
    vecs[5] = mkvec(16'hF000, 16'h0000, 16'h0800, 16'h0400, 16'h0000,
                    9'h1FF, 9'h000, 9'h000);

    rst   = 1'b1;
    start = 1'b0;
    a1    = '0;
    a2    = '0;
    for (int g = 0; g < NC; g++) out_prev[g] = '0;
    repeat (3) @(negedge clk);
    check_zero("in_reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_zero("idle");

    // Table-driven vectors; config 3 takes its expectations from the model.
    for (int v = 0; v < 6; v++) begin
      for (int g = 0; g < 3; g++) begin
        for (int i = 0; i < 9; i++) exp_p[g][i] = vecs[v].p[g];
        exp_o[g] = vecs[v].o[g];
      end
      fill_model(3, vecs[v].a1, vecs[v].a2);
      run_decode(vecs[v].a1, vecs[v].a2, v == 1);
    end

    // Reset in the middle of a decode: outputs clear at once, partial bits are discarded.
    start = 1'b1;
    a1    = 16'h2000;
    a2    = 16'h1000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("rst_async");
    @(negedge clk);
    check_zero("rst_held");
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < NC; g++) out_prev[g] = '0;
    @(negedge clk);
    for (int g = 0; g < NC; g++) fill_model(g, 16'h2000, 16'h1000);
    run_decode(16'h2000, 16'h1000, 1'b0);

    // Randomized decodes against the reference model, with latent edge values mixed in.
    for (int k = 0; k < 16; k++) begin
      ra1 = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(3)] : 16'($urandom);
      ra2 = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(3)] : 16'($urandom);
      for (int g = 0; g < NC; g++) fill_model(g, ra1, ra2);
      run_decode(ra1, ra2, k % 2 == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
